// File: rtl/axi_read_responder.sv
// AXI read-channel slave that serves INCR/FIXED bursts from a 1-cycle-latency SRAM.
// One SRAM access per beat; unsupported size/burst requests return SLVERR beats.
module axi_read_responder #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID_i,
  input  logic [ADDR_W-1:0] ARADDR_i,
  input  logic [LEN_W-1:0]  ARLEN_i,
  input  logic [2:0]        ARSIZE_i,
  input  logic [1:0]        ARBURST_i,
  input  logic              ARVALID_i,
  output logic              ARREADY_o,
  output logic [ID_W-1:0]   RID_o,
  output logic [DATA_W-1:0] RDATA_o,
  output logic [1:0]        RRESP_o,
  output logic              RLAST_o,
  output logic              RVALID_o,
  input  logic              RREADY_i,
  output logic              mem_cs_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_e;

  state_e            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  len_q;
  logic [MEM_AW-1:0] addr_q;
  logic              incr_q;
  logic              err_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic              arready_q;

  logic              ar_hs;
  logic              r_hs;
  logic              ar_err;
  logic [MEM_AW-1:0] ar_waddr;
  logic [MEM_AW-1:0] addr_d;
  logic              unused_addr_bits;

  assign ar_hs    = (state_q == IDLE) & ARVALID_i;
  assign r_hs     = rvalid_q & RREADY_i;
  assign ar_err   = (ARSIZE_i != 3'b010) | ARBURST_i[1];
  assign ar_waddr = ARADDR_i[MEM_AW+1:2];
  assign addr_d   = incr_q ? addr_q + MEM_AW'(1) : addr_q;

  // Byte lane and out-of-macro address bits carry no meaning for a word SRAM.
  assign unused_addr_bits = ^{ARADDR_i[ADDR_W-1:MEM_AW+2], ARADDR_i[1:0]};

  // The SRAM is strobed in the handshake cycle itself so data lands during FETCH.
  assign mem_cs_o   = (ar_hs & ~ar_err) | (r_hs & ~rlast_q & ~err_q);
  assign mem_addr_o = (state_q == IDLE) ? ar_waddr : addr_d;

  assign ARREADY_o = arready_q;
  assign RID_o     = rid_q;
  assign RDATA_o   = rdata_q;
  assign RRESP_o   = rresp_q;
  assign RLAST_o   = rlast_q;
  assign RVALID_o  = rvalid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      incr_q    <= 1'b0;
      err_q     <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      arready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (ar_hs) begin
            rid_q     <= ARID_i;
            addr_q    <= ar_waddr;
            len_q     <= ARLEN_i;
            incr_q    <= (ARBURST_i == 2'b01);
            err_q     <= ar_err;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          rdata_q  <= err_q ? '0 : mem_rdata_i;
          rresp_q  <= err_q ? RESP_SLVERR : RESP_OKAY;
          rlast_q  <= (cnt_q == len_q);
          rvalid_q <= 1'b1;
          state_q  <= RESP;
        end
        RESP: begin
          // Beat outputs hold until the master takes the beat.
          if (r_hs) begin
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              cnt_q   <= cnt_q + LEN_W'(1);
              addr_q  <= addr_d;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: directed burst scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the R channel and SRAM strobes.
module tb_axi_read_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ARID_i;
  logic [31:0] ARADDR_i;
  logic [3:0]  ARLEN_i;
  logic [2:0]  ARSIZE_i;
  logic [1:0]  ARBURST_i;
  logic        ARVALID_i;
  logic        ARREADY_o;
  logic [7:0]  RID_o;
  logic [31:0] RDATA_o;
  logic [1:0]  RRESP_o;
  logic        RLAST_o;
  logic        RVALID_o;
  logic        RREADY_i;
  logic        mem_cs_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_rdata_i;

  axi_read_responder dut (
    .clk(clk), .rst(rst),
    .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
    .ARBURST_i(ARBURST_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
    .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
    .mem_cs_o(mem_cs_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        err;
    logic [13:0] addr;
  } beat_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    int          cyc;
  } obs_t;

  logic [31:0] mem [0:16383];
  beat_t       exp_q[$];
  obs_t        obs[$];
  logic [13:0] cs_log[$];
  int          tests = 0;
  int          failed = 0;
  int          cyc = 0;
  int          due = 0;
  int          hs_cyc = 0;
  bit          busy = 0;
  bit          post_rst = 0;
  int          rmode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // SRAM: one-cycle read latency; garbage whenever no read was strobed.
  initial forever begin
    @(posedge clk);
    mem_rdata_i <= mem_cs_o ? mem[mem_addr_o] : $urandom;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model and per-cycle comparison, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      busy = 0;
      post_rst = 1;
    end else begin
      bit          exp_rv;
      bit          e_cs;
      logic [13:0] e_addr;
      if (post_rst) begin
        chk("rst_rvalid", RVALID_o, 0);
        chk("rst_rlast", RLAST_o, 0);
        chk("rst_rdata", RDATA_o, 0);
        chk("rst_rid", RID_o, 0);
        chk("rst_rresp", RRESP_o, 0);
        post_rst = 0;
      end
      exp_rv = busy && (cyc >= due);
      chk("rvalid", RVALID_o, exp_rv);
      chk("arready", ARREADY_o, !busy);
      if (exp_rv && exp_q.size() > 0) begin
        chk("rid", RID_o, exp_q[0].id);
        chk("rdata", RDATA_o, exp_q[0].data);
        chk("rresp", RRESP_o, exp_q[0].resp);
        chk("rlast", RLAST_o, exp_q[0].last);
      end
      e_cs = 0;
      e_addr = '0;
      if (!busy && ARVALID_i) begin
        logic [13:0] wa;
        bit          err;
        bit          incr;
        wa   = ARADDR_i[15:2];
        err  = (ARSIZE_i != 3'b010) || (ARBURST_i > 2'd1);
        incr = (ARBURST_i == 2'd1);
        for (int k = 0; k <= int'(ARLEN_i); k++) begin
          beat_t b;
          b.id   = ARID_i;
          b.addr = incr ? 14'((int'(wa) + k) % 16384) : wa;
          b.data = err ? 32'h0 : mem[b.addr];
          b.resp = err ? 2'b10 : 2'b00;
          b.last = (k == int'(ARLEN_i));
          b.err  = err;
          exp_q.push_back(b);
        end
        busy   = 1;
        due    = cyc + 2;
        hs_cyc = cyc;
        e_cs   = !err;
        e_addr = wa;
      end else if (exp_rv && RREADY_i && exp_q.size() > 0) begin
        beat_t b;
        obs_t  o;
        b = exp_q.pop_front();
        o.id = RID_o; o.data = RDATA_o; o.resp = RRESP_o; o.last = RLAST_o; o.cyc = cyc;
        obs.push_back(o);
        if (b.last) begin
          busy = 0;
        end else begin
          due = cyc + 2;
          e_cs = !b.err;
          if (exp_q.size() > 0) e_addr = exp_q[0].addr;
        end
      end
      chk("mem_cs", mem_cs_o, e_cs);
      if (e_cs) chk("mem_addr", mem_addr_o, e_addr);
      if (mem_cs_o === 1'b1) cs_log.push_back(mem_addr_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rready();
    if (rmode == 0) RREADY_i = 1'b1;
    else if (rmode == 1) RREADY_i = ($urandom_range(9) < 7);
  endtask

  task automatic issue(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    bit hs;
    int n;
    ARID_i = id; ARADDR_i = addr; ARLEN_i = len; ARSIZE_i = size; ARBURST_i = burst;
    ARVALID_i = 1'b1;
    hs = 0;
    n = 0;
    while (!hs && n < 200) begin
      drive_rready();
      @(negedge clk);
      hs = ARREADY_o;
      tick();
      n++;
    end
    if (!hs) chk("ar_timeout", 0, 1);
    ARVALID_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && n < 300) begin
      drive_rready();
      tick();
      n++;
    end
    if (busy) chk("drain_timeout", busy, 0);
  endtask

  task automatic clear_logs();
    obs.delete();
    cs_log.delete();
  endtask

  initial begin
    int t;
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + i;
    mem[14'h40]   = 32'hDEAD_0040;
    mem[14'h3FFF] = 32'hCAFE_3FFF;

    rst = 1'b1; ARVALID_i = 1'b0; RREADY_i = 1'b0;
    ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0; ARSIZE_i = 3'b010; ARBURST_i = 2'b01;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_arready", ARREADY_o, 1);
    chk("reset_rvalid", RVALID_o, 0);
    chk("reset_mem_cs", mem_cs_o, 0);

    // Single-beat INCR read, then a new request in the cycle ARREADY returns.
    rmode = 0;
    clear_logs();
    issue(8'h15, 32'h100, 4'd0, 3'b010, 2'b01);
    t = hs_cyc;
    drain();
    chk("t1_nbeats", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("t1_data", obs[0].data, 32'hDEAD_0040);
      chk("t1_id", obs[0].id, 8'h15);
      chk("t1_last", obs[0].last, 1);
      chk("t1_resp", obs[0].resp, 2'b00);
      chk("t1_cycle", obs[0].cyc, t + 2);
    end
    chk("t1_cs_count", cs_log.size(), 1);
    if (cs_log.size() >= 1) chk("t1_cs_addr", cs_log[0], 14'h40);

    clear_logs();
    issue(8'h21, 32'h0, 4'd3, 3'b010, 2'b01);
    chk("t2_hs_cycle", hs_cyc, t + 3);
    t = hs_cyc;
    drain();
    chk("t2_nbeats", obs.size(), 4);
    for (int k = 0; k < 4 && k < obs.size(); k++) begin
      chk("t2_data", obs[k].data, 32'h1000_0000 + k);
      chk("t2_last", obs[k].last, k == 3);
      chk("t2_cycle", obs[k].cyc, t + 2 + 2 * k);
    end
    chk("t2_cs_count", cs_log.size(), 4);

    // Master stalls beat 1 for five cycles.
    rmode = 2;
    RREADY_i = 1'b1;
    clear_logs();
    issue(8'h33, 32'h0, 4'd3, 3'b010, 2'b01);
    t = hs_cyc;
    tick();
    tick();
    RREADY_i = 1'b0;
    repeat (6) tick();
    RREADY_i = 1'b1;
    drain();
    chk("t3_nbeats", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("t3_b1_cycle", obs[1].cyc, t + 9);
      chk("t3_b3_cycle", obs[3].cyc, t + 13);
      chk("t3_b1_data", obs[1].data, 32'h1000_0001);
      chk("t3_b3_data", obs[3].data, 32'h1000_0003);
      chk("t3_b3_last", obs[3].last, 1);
    end
    chk("t3_cs_count", cs_log.size(), 4);

    // FIXED at the top word, then INCR wrapping past it.
    rmode = 0;
    clear_logs();
    issue(8'h44, 32'hFFFC, 4'd3, 3'b010, 2'b00);
    drain();
    chk("t4f_nbeats", obs.size(), 4);
    for (int k = 0; k < obs.size(); k++) chk("t4f_data", obs[k].data, 32'hCAFE_3FFF);
    clear_logs();
    issue(8'h45, 32'hFFFC, 4'd3, 3'b010, 2'b01);
    drain();
    chk("t4i_nbeats", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("t4i_d0", obs[0].data, 32'hCAFE_3FFF);
      chk("t4i_d1", obs[1].data, 32'h1000_0000);
      chk("t4i_d3", obs[3].data, 32'h1000_0002);
    end

    // Unsupported burst type and unsupported size.
    clear_logs();
    issue(8'h55, 32'h40, 4'd1, 3'b010, 2'b10);
    drain();
    chk("t5a_nbeats", obs.size(), 2);
    for (int k = 0; k < obs.size(); k++) begin
      chk("t5a_resp", obs[k].resp, 2'b10);
      chk("t5a_data", obs[k].data, 32'h0);
      chk("t5a_last", obs[k].last, k == 1);
    end
    chk("t5a_no_cs", cs_log.size(), 0);
    clear_logs();
    issue(8'h56, 32'h40, 4'd0, 3'b011, 2'b01);
    drain();
    chk("t5b_nbeats", obs.size(), 1);
    if (obs.size() == 1) chk("t5b_resp", obs[0].resp, 2'b10);
    chk("t5b_no_cs", cs_log.size(), 0);

    // Reset while beat 1 of an 8-beat burst is on the bus.
    clear_logs();
    issue(8'h42, 32'h200, 4'd7, 3'b010, 2'b01);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rvalid", RVALID_o, 0);
    chk("t6_arready", ARREADY_o, 1);
    chk("t6_beats_before_rst", obs.size(), 1);
    clear_logs();
    issue(8'h77, 32'h100, 4'd0, 3'b010, 2'b01);
    repeat (6) tick();
    chk("t6_nbeats", obs.size(), 1);
    if (obs.size() == 1) begin
      chk("t6_id", obs[0].id, 8'h77);
      chk("t6_data", obs[0].data, 32'hDEAD_0040);
    end

    // Randomized traffic with random back-pressure and request gaps.
    rmode = 1;
    for (int n = 0; n < 60; n++) begin
      logic [1:0] burst;
      logic [2:0] size;
      burst = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'($urandom_range(1));
      size  = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'b010;
      repeat ($urandom_range(3)) begin
        drive_rready();
        tick();
      end
      issue(8'($urandom), $urandom, 4'($urandom_range(15)), size, burst);
    end
    drain();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
